// File: rtl/asip_vga_core.sv
// asip_vga_core: switch-configured 3-lane SIMD LUT builder feeding a VGA 640x480@60 gradient scan-out (in: clk, rst, lane codes, gtype, switchStart; out: rgb, h_sync, v_sync, vga_clk)
module asip_vga_core #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int LUT_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  red_switches,
  input  logic [1:0]  green_switches,
  input  logic [1:0]  blue_switches,
  input  logic        gtype_switch,
  input  logic        switchStart,
  output logic [23:0] rgb,
  output logic        v_sync,
  output logic        h_sync,
  output logic        vga_clk
);
  localparam int AW = $clog2(LUT_DEPTH);
  localparam logic [9:0] H_VIS = 10'(H_ACTIVE);
  localparam logic [9:0] H_SLO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SHI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
  localparam logic [9:0] V_SLO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SHI = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [AW-1:0] A_LAST = AW'(LUT_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, COMPUTE, DISPLAY} state_t;
  state_t r_state, w_state_nxt;
  logic w_latch, w_lut_we, w_pix_en, w_active, w_hs, w_vs;
  logic r_vga_clk, r_h_sync, r_v_sync, r_lut_valid, r_gtype;
  logic [9:0] r_hcnt, r_vcnt;
  logic [23:0] r_rgb, w_pixel;
  logic [1:0] r_code_r, r_code_g, r_code_b;
  logic [AW-1:0] r_addr, w_idx;
  logic [7:0] r_lut_r [LUT_DEPTH];
  logic [7:0] r_lut_g [LUT_DEPTH];
  logic [7:0] r_lut_b [LUT_DEPTH];
  function automatic logic [7:0] f_lane(input logic [1:0] code, input logic [AW-1:0] i);
    return code == 2'd0 ? 8'd0 : 8'(i >> (2'd3 - code));
  endfunction
  always_comb begin
    w_state_nxt = r_state;
    w_latch = 1'b0;
    w_lut_we = 1'b0;
    case (r_state)
      IDLE: begin
        w_latch = ~switchStart;
        w_state_nxt = switchStart ? IDLE : COMPUTE;
      end
      COMPUTE: begin
        w_lut_we = 1'b1;
        w_state_nxt = r_addr == A_LAST ? DISPLAY : COMPUTE;
      end
      DISPLAY: w_state_nxt = switchStart ? IDLE : DISPLAY;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_code_r <= 2'd0;
      r_code_g <= 2'd0;
      r_code_b <= 2'd0;
      r_gtype <= 1'b0;
      r_addr <= '0;
      r_lut_valid <= 1'b0;
    end else if (w_latch) begin
      r_code_r <= red_switches;
      r_code_g <= green_switches;
      r_code_b <= blue_switches;
      r_gtype <= gtype_switch;
      r_addr <= '0;
      r_lut_valid <= 1'b0;
    end else if (w_lut_we) begin
      r_addr <= r_addr + 1'b1;
      r_lut_valid <= r_addr == A_LAST;
    end
  end
  always_ff @(posedge clk) begin
    if (w_lut_we) begin
      r_lut_r[r_addr] <= f_lane(r_code_r, r_addr);
      r_lut_g[r_addr] <= f_lane(r_code_g, r_addr);
      r_lut_b[r_addr] <= f_lane(r_code_b, r_addr);
    end
  end
  assign w_pix_en = ~r_vga_clk;
  assign w_active = r_hcnt < H_VIS && r_vcnt < V_VIS;
  assign w_hs = ~(r_hcnt >= H_SLO && r_hcnt < H_SHI);
  assign w_vs = ~(r_vcnt >= V_SLO && r_vcnt < V_SHI);
  assign w_idx = r_gtype ? AW'(r_vcnt[8:1]) : AW'(r_hcnt[9:2]);
  assign w_pixel = {r_lut_r[w_idx], r_lut_g[w_idx], r_lut_b[w_idx]};
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vga_clk <= 1'b0;
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
      r_h_sync <= 1'b1;
      r_v_sync <= 1'b1;
      r_rgb <= 24'd0;
    end else begin
      r_vga_clk <= ~r_vga_clk;
      if (w_pix_en) begin
        r_hcnt <= r_hcnt == H_LAST ? 10'd0 : r_hcnt + 10'd1;
        if (r_hcnt == H_LAST) r_vcnt <= r_vcnt == V_LAST ? 10'd0 : r_vcnt + 10'd1;
        r_h_sync <= w_hs;
        r_v_sync <= w_vs;
        r_rgb <= r_state == DISPLAY && r_lut_valid && w_active ? w_pixel : 24'd0;
      end
    end
  end
  assign rgb = r_rgb;
  assign h_sync = r_h_sync;
  assign v_sync = r_v_sync;
  assign vga_clk = r_vga_clk;
endmodule

// File: tb/tb_asip_vga_core.sv
// tb_asip_vga_core: pixel-count model plus directed checks for two asip_vga_core instances (full-width lines, full-height frames)
module tb_asip_vga_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] rs = 2'd0, gs = 2'd0, bs = 2'd0;
  logic gt = 1'b0, ss = 1'b1;
  logic [23:0] rgb0, rgb1;
  logic hs0, hs1, vs0, vs1, vc0, vc1;
  int errors = 0, checks = 0;
  int HA[2] = '{640, 16};
  int HF[2] = '{16, 2};
  int HS[2] = '{96, 4};
  int HT[2] = '{800, 24};
  int VA[2] = '{8, 480};
  int VF[2] = '{2, 10};
  int VS[2] = '{2, 2};
  int VT[2] = '{16, 525};
  always #5 clk = ~clk;
  asip_vga_core #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(4)) dut_h (
    .clk(clk), .rst(rst), .red_switches(rs), .green_switches(gs), .blue_switches(bs),
    .gtype_switch(gt), .switchStart(ss), .rgb(rgb0), .v_sync(vs0), .h_sync(hs0), .vga_clk(vc0));
  asip_vga_core #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2)) dut_v (
    .clk(clk), .rst(rst), .red_switches(rs), .green_switches(gs), .blue_switches(bs),
    .gtype_switch(gt), .switchStart(ss), .rgb(rgb1), .v_sync(vs1), .h_sync(hs1), .vga_clk(vc1));
  function automatic logic [7:0] lane(int code, int i);
    return code == 0 ? 8'd0 : 8'((i * (1 << code)) / 8);
  endfunction
  int m_p, m_mode, m_cnt, m_cr, m_cg, m_cb;
  bit m_ok = 1'b0, m_vclk, m_gt;
  logic [23:0] m_rgb[2];
  bit m_hs[2], m_vs[2];
  int m_hl[2], m_vl[2];
  always @(posedge clk) begin
    int h, v, idx;
    if (!rst) begin
      m_ok <= 1'b1;
      m_p <= 0;
      m_vclk <= 1'b0;
      m_mode <= 0;
      m_cnt <= 0;
      m_cr <= 0;
      m_cg <= 0;
      m_cb <= 0;
      m_gt <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_rgb[k] <= 24'd0;
        m_hs[k] <= 1'b1;
        m_vs[k] <= 1'b1;
        m_hl[k] <= -1;
        m_vl[k] <= -1;
      end
    end else begin
      if (!m_vclk) begin
        for (int k = 0; k < 2; k++) begin
          h = m_p % HT[k];
          v = (m_p / HT[k]) % VT[k];
          idx = m_gt ? v / 2 : h / 4;
          m_hl[k] <= h;
          m_vl[k] <= v;
          m_hs[k] <= !(h >= HA[k] + HF[k] && h < HA[k] + HF[k] + HS[k]);
          m_vs[k] <= !(v >= VA[k] + VF[k] && v < VA[k] + VF[k] + VS[k]);
          m_rgb[k] <= (m_mode == 2 && h < HA[k] && v < VA[k]) ? {lane(m_cr, idx), lane(m_cg, idx), lane(m_cb, idx)} : 24'd0;
        end
        m_p <= m_p + 1;
      end
      m_vclk <= !m_vclk;
      if (m_mode == 0 && !ss) begin
        m_mode <= 1;
        m_cnt <= 0;
        m_cr <= int'(rs);
        m_cg <= int'(gs);
        m_cb <= int'(bs);
        m_gt <= gt;
      end else if (m_mode == 1) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 255) m_mode <= 2;
      end else if (m_mode == 2 && ss) m_mode <= 0;
    end
  end
  task automatic chk(input string n, input logic [23:0] a, input logic [23:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (m_ok) begin
      chk("rgb_h", rgb0, m_rgb[0]);
      chk("rgb_v", rgb1, m_rgb[1]);
      chk("hsync_h", {23'd0, hs0}, {23'd0, m_hs[0]});
      chk("hsync_v", {23'd0, hs1}, {23'd0, m_hs[1]});
      chk("vsync_h", {23'd0, vs0}, {23'd0, m_vs[0]});
      chk("vsync_v", {23'd0, vs1}, {23'd0, m_vs[1]});
      chk("vgaclk_h", {23'd0, vc0}, {23'd0, m_vclk});
      chk("vgaclk_v", {23'd0, vc1}, {23'd0, m_vclk});
    end
  end
  function automatic logic sig(int s);
    return s == 0 ? hs0 : s == 1 ? vs0 : vs1;
  endfunction
  task automatic measure(input int s, input int budget, input bit want_per, output int lo, output int per);
    int t = 0;
    lo = 0;
    per = 0;
    while (sig(s) == 1'b0 && t < budget) begin @(negedge clk); t++; end
    while (sig(s) == 1'b1 && t < budget) begin @(negedge clk); t++; end
    while (sig(s) == 1'b0 && t < budget) begin @(negedge clk); t++; lo++; end
    if (want_per) begin
      while (sig(s) == 1'b1 && t < budget) begin @(negedge clk); t++; per++; end
      per += lo;
    end
  endtask
  task automatic wait_at(input int k, input int h, input int v, input int budget, input string n);
    int t = 0;
    while (!(m_hl[k] == h && (v == -2 || (v == -1 ? m_vl[k] < VA[k] : m_vl[k] == v))) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out after %0d clocks", n, t);
    end
  endtask
  initial begin
    int lo, per;
    repeat (4) @(negedge clk);
    chk("reset_rgb", rgb0, 24'd0);
    chk("reset_hsync", {23'd0, hs0}, 24'd1);
    chk("reset_vsync", {23'd0, vs1}, 24'd1);
    chk("reset_vgaclk", {23'd0, vc0}, 24'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("vgaclk_first_high", {23'd0, vc0}, 24'd1);
    @(negedge clk);
    chk("vgaclk_then_low", {23'd0, vc0}, 24'd0);
    measure(0, 5000, 1'b1, lo, per);
    chk("hsync_low_192", 24'(lo), 24'd192);
    chk("hsync_period_1600", 24'(per), 24'd1600);
    measure(1, 30000, 1'b0, lo, per);
    chk("vsync_low_3200", 24'(lo), 24'd3200);
    measure(2, 30000, 1'b0, lo, per);
    chk("vsync_low_96", 24'(lo), 24'd96);
    rs = 2'd3; gs = 2'd0; bs = 2'd0; gt = 1'b0; ss = 1'b0;
    repeat (10) @(negedge clk);
    rs = 2'd0; gs = 2'd3; gt = 1'b1; ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
    wait_at(0, 400, -1, 30000, "wait_h400");
    chk("h400_red_full", rgb0, 24'h640000);
    wait_at(0, 700, -1, 2000, "wait_h700");
    chk("h700_blank", rgb0, 24'd0);
    wait_at(0, 100, -1, 2000, "wait_h100");
    chk("h100_red_full", rgb0, 24'h190000);
    ss = 1'b1;
    repeat (3) @(negedge clk);
    chk("stop_blank", rgb0, 24'd0);
    rs = 2'd1; gs = 2'd2; bs = 2'd3; gt = 1'b1; ss = 1'b0;
    wait_at(1, 5, 200, 30000, "wait_v200");
    chk("v200_scaled", rgb1, {8'd25, 8'd50, 8'd100});
    rs = 2'd0; gs = 2'd0; bs = 2'd0; gt = 1'b0;
    wait_at(1, 5, 201, 200, "wait_v201");
    chk("v201_after_toggle", rgb1, {8'd25, 8'd50, 8'd100});
    wait_at(0, 700, -2, 4000, "wait_hsync");
    chk("hsync_low_pre_rst", {23'd0, hs0}, 24'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rgb", rgb1, 24'd0);
    chk("rst_hsync", {23'd0, hs0}, 24'd1);
    chk("rst_vsync", {23'd0, vs0}, 24'd1);
    chk("rst_vgaclk", {23'd0, vc0}, 24'd0);
    rst = 1'b1;
    repeat (1500) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
